cruise_speed_controller: RTL and testbench
==========================================

// Module: cruise_speed_controller
// PURPOSE
//  Sequences the 8-bit cruise target-speed register (eight_bit_parallel_register) from driver controls.
//  Debounced buttons are edge-detected; a 3-state FSM decides when to load, adjust, hold or clear the target.
//  Keeps a shadow copy of the target and drives the register's in/enable/clear/preset pins directly.
//  Sits between the button/brake interface and the speed-regulation datapath.
// PARAMETERS
//  MIN_SPEED  30   lowest engageable/adjustable target (8-bit unsigned)
//  MAX_SPEED  200  highest adjustable target; MIN_SPEED < MAX_SPEED <= 255
//  STEP       5    target change per accel/decel press, 1..255
// PORTS
//  clk            in   1  system clock, rising edge
//  clear          in   1  synchronous, active-high reset
//  speed          in   8  current vehicle speed, unsigned
//  set_btn        in   1  set/engage at current speed (level, debounced)
//  resume_btn     in   1  resume to stored target
//  cancel_btn     in   1  suspend cruise, keep target
//  off_btn        in   1  disable cruise, discard target
//  brake          in   1  brake pedal (level)
//  accel_btn      in   1  target += STEP
//  decel_btn      in   1  target -= STEP
//  reg_in         out  8  data to register 'in'
//  reg_enable     out  1  register 'enable' (one-cycle load pulse)
//  reg_clear      out  1  register 'clear'
//  reg_preset     out  1  register 'preset'; constant 0
//  cruise_active  out  1  1 only in ACTIVE
//  state          out  2  FSM state: 00 IDLE, 01 ACTIVE, 10 SUSPENDED
// BEHAVIOUR
//  - All outputs registered. Reset (clear=1 at edge): state=IDLE, target=0, reg_in=0, reg_enable=0,
//    reg_clear=1, cruise_active=0; button history regs load the current button levels, so a button
//    held through reset does not fire.
//  - Events: rising edge of each button (level now 1, history 0); brake is level-sensitive.
//  - Per cycle, exactly one event acts, priority: brake > off > cancel > set > resume > accel/decel.
//    accel and decel both rising in the same cycle -> neither acts.
//  - reg_enable=1 for exactly one cycle per target write, with reg_in = new target in that cycle.
//    Register captures on the next edge: reg_out valid 2 edges after the button edge is sampled.
//  - reg_clear=1 for exactly one cycle on off; 0 otherwise, except during reset.
//  - IDLE: set & speed>=MIN_SPEED -> target=speed, write, ACTIVE.
//    set & speed<MIN_SPEED -> ignored. Every other event -> ignored.
//  - ACTIVE:
//      brake or cancel -> SUSPENDED, target kept, no write.
//      off -> IDLE, target=0, reg_clear pulse.
//      set -> reload target=speed if speed>=MIN_SPEED, else ignored; stays ACTIVE.
//      accel -> target=min(target+STEP, MAX_SPEED), computed in 9 bits (no 8-bit wrap).
//      decel -> target=max(target-STEP, MIN_SPEED), computed signed (no underflow).
//      A write is issued even if saturation leaves the value unchanged.
//  - SUSPENDED:
//      resume & !brake -> ACTIVE, no write.
//      set & !brake & speed>=MIN_SPEED -> target=speed, write, ACTIVE.
//      off -> IDLE + clear pulse. accel/decel/cancel -> ignored.
//      Brake held blocks set/resume for every cycle it is high.
//  - Reset mid-operation wins over any event in the same cycle; unused state 11 -> IDLE next cycle.
// TESTING
//  1. Reset, speed=25, set -> no write, IDLE. speed=60, set -> reg_enable pulse, reg_in=60, ACTIVE,
//     register out=60 two edges later.
//  2. ACTIVE target=60: accel x3 -> writes 65,70,75. Target=198: accel -> 200; accel again -> 200 (write still pulsed).
//  3. Target=32: decel -> 30; decel -> 30. Accel+decel same cycle -> no write.
//  4. Target=75, brake -> SUSPENDED, cruise_active=0. Resume with brake=1 -> stays SUSPENDED.
//     Resume after brake=0 -> ACTIVE, register still 75, no write.
//  5. ACTIVE, off -> reg_clear 1-cycle pulse, register out=0, IDLE.
//     set held through reset -> no engage after reset release.
//  6. Reset asserted in the same cycle as set (speed=80) -> IDLE, no write, reg_clear=1.

Source files
------------

// File: rtl/cruise_speed_controller.sv
// Cruise target-speed sequencer: edge-detects driver buttons and drives the target register's load/clear pins.
// One-cycle latency from sampled button edge to registered reg_* outputs; no backpressure, one event per cycle.
module cruise_speed_controller #(
    parameter logic [7:0] MIN_SPEED = 8'd30,
    parameter logic [7:0] MAX_SPEED = 8'd200,
    parameter logic [7:0] STEP      = 8'd5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] speed,
    input  logic       set_btn,
    input  logic       resume_btn,
    input  logic       cancel_btn,
    input  logic       off_btn,
    input  logic       brake,
    input  logic       accel_btn,
    input  logic       decel_btn,
    output logic [7:0] reg_in,
    output logic       reg_enable,
    output logic       reg_clear,
    output logic       reg_preset,
    output logic       cruise_active,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ACTIVE    = 2'b01,
        SUSPENDED = 2'b10,
        UNUSED    = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_BRAKE, EV_OFF, EV_CANCEL, EV_SET, EV_RESUME, EV_ACCEL, EV_DECEL
    } event_t;

    state_t     state_q, state_d;
    logic [7:0] target_q, target_d;
    logic [7:0] reg_in_q, reg_in_d;
    logic       reg_enable_q, reg_enable_d;
    logic       reg_clear_q, reg_clear_d;
    logic       cruise_active_q, cruise_active_d;
    logic [5:0] btn_hist_q, btn_hist_d;

    logic [5:0]        btn_lvl;
    logic [5:0]        btn_rise;
    event_t            ev;
    logic [8:0]        sum9;
    logic signed [9:0] diff;
    logic              speed_ok;

    // Bit order: set, resume, cancel, off, accel, decel
    assign btn_lvl  = {set_btn, resume_btn, cancel_btn, off_btn, accel_btn, decel_btn};
    assign btn_rise = btn_lvl & ~btn_hist_q;
    assign speed_ok = (speed >= MIN_SPEED);
    assign sum9     = {1'b0, target_q} + {1'b0, STEP};
    assign diff     = $signed({2'b00, target_q}) - $signed({2'b00, STEP});

    always_comb begin
        ev = EV_NONE;
        if (brake)                         ev = EV_BRAKE;
        else if (btn_rise[2])              ev = EV_OFF;
        else if (btn_rise[3])              ev = EV_CANCEL;
        else if (btn_rise[5])              ev = EV_SET;
        else if (btn_rise[4])              ev = EV_RESUME;
        else if (btn_rise[1] && !btn_rise[0]) ev = EV_ACCEL;
        else if (btn_rise[0] && !btn_rise[1]) ev = EV_DECEL;
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        reg_enable_d = 1'b0;
        reg_clear_d  = 1'b0;
        btn_hist_d   = btn_lvl;

        unique case (state_q)
            IDLE: begin
                if (ev == EV_SET && speed_ok) begin
                    target_d     = speed;
                    reg_enable_d = 1'b1;
                    state_d      = ACTIVE;
                end
            end
            ACTIVE: begin
                case (ev)
                    EV_BRAKE, EV_CANCEL: state_d = SUSPENDED;
                    EV_OFF: begin
                        target_d    = 8'd0;
                        reg_clear_d = 1'b1;
                        state_d     = IDLE;
                    end
                    EV_SET: begin
                        if (speed_ok) begin
                            target_d     = speed;
                            reg_enable_d = 1'b1;
                        end
                    end
                    // Saturated results are still written so every press yields a load pulse
                    EV_ACCEL: begin
                        target_d     = (sum9 > {1'b0, MAX_SPEED}) ? MAX_SPEED : sum9[7:0];
                        reg_enable_d = 1'b1;
                    end
                    EV_DECEL: begin
                        target_d     = (diff < $signed({2'b00, MIN_SPEED})) ? MIN_SPEED : diff[7:0];
                        reg_enable_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            SUSPENDED: begin
                case (ev)
                    EV_RESUME: state_d = ACTIVE;
                    EV_SET: begin
                        if (speed_ok) begin
                            target_d     = speed;
                            reg_enable_d = 1'b1;
                            state_d      = ACTIVE;
                        end
                    end
                    EV_OFF: begin
                        target_d    = 8'd0;
                        reg_clear_d = 1'b1;
                        state_d     = IDLE;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d  = IDLE;
                target_d = 8'd0;
            end
        endcase

        reg_in_d        = reg_enable_d ? target_d : reg_in_q;
        cruise_active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q         <= IDLE;
            target_q        <= 8'd0;
            reg_in_q        <= 8'd0;
            reg_enable_q    <= 1'b0;
            reg_clear_q     <= 1'b1;
            cruise_active_q <= 1'b0;
            btn_hist_q      <= btn_lvl;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            reg_in_q        <= reg_in_d;
            reg_enable_q    <= reg_enable_d;
            reg_clear_q     <= reg_clear_d;
            cruise_active_q <= cruise_active_d;
            btn_hist_q      <= btn_hist_d;
        end
    end

    assign reg_in        = reg_in_q;
    assign reg_enable    = reg_enable_q;
    assign reg_clear     = reg_clear_q;
    assign reg_preset    = 1'b0;
    assign cruise_active = cruise_active_q;
    assign state         = state_q;

endmodule

// File: tb/tb_cruise_speed_controller.sv
// Bench for cruise_speed_controller: directed scenarios plus randomized traffic against a behavioural model,
// with a model of the downstream target register driven from the DUT's reg_* pins.
module tb_cruise_speed_controller;

    localparam int MIN_S = 30;
    localparam int MAX_S = 200;
    localparam int STP   = 5;

    localparam int E_NONE = 0, E_BRAKE = 1, E_OFF = 2, E_CANCEL = 3, E_SET = 4,
                   E_RESUME = 5, E_ACCEL = 6, E_DECEL = 7;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] speed = 8'd0;
    logic       set_btn = 0, resume_btn = 0, cancel_btn = 0, off_btn = 0;
    logic       brake = 0, accel_btn = 0, decel_btn = 0;
    logic [7:0] reg_in;
    logic       reg_enable, reg_clear, reg_preset, cruise_active;
    logic [1:0] state;
    logic [7:0] tb_reg = 8'd0;

    int checks = 0;
    int errors = 0;

    int m_state = 0, m_target = 0, m_en = 0, m_clr = 0, m_in = 0, m_reg = 0;
    bit [5:0] m_hist = '0;

    cruise_speed_controller dut (
        .clk(clk), .clear(clear), .speed(speed),
        .set_btn(set_btn), .resume_btn(resume_btn), .cancel_btn(cancel_btn),
        .off_btn(off_btn), .brake(brake), .accel_btn(accel_btn), .decel_btn(decel_btn),
        .reg_in(reg_in), .reg_enable(reg_enable), .reg_clear(reg_clear),
        .reg_preset(reg_preset), .cruise_active(cruise_active), .state(state)
    );

    always #5 clk = ~clk;

    // Downstream eight_bit_parallel_register
    always @(posedge clk) begin
        if (reg_clear)       tb_reg <= 8'd0;
        else if (reg_preset) tb_reg <= 8'hFF;
        else if (reg_enable) tb_reg <= reg_in;
    end

    task automatic model_load(input int v);
        m_target = v;
        m_en     = 1;
        m_in     = v;
    endtask

    task automatic model_update();
        bit [5:0] lv, r;
        int ev;
        if (m_clr != 0)      m_reg = 0;
        else if (m_en != 0)  m_reg = m_in;
        lv = {set_btn, resume_btn, cancel_btn, off_btn, accel_btn, decel_btn};
        r  = lv & ~m_hist;
        m_hist = lv;
        m_en  = 0;
        m_clr = 0;
        if (clear) begin
            m_state = 0; m_target = 0; m_in = 0; m_clr = 1;
            return;
        end
        if (brake)                  ev = E_BRAKE;
        else if (r[2])              ev = E_OFF;
        else if (r[3])              ev = E_CANCEL;
        else if (r[5])              ev = E_SET;
        else if (r[4])              ev = E_RESUME;
        else if (r[1] && !r[0])     ev = E_ACCEL;
        else if (r[0] && !r[1])     ev = E_DECEL;
        else                        ev = E_NONE;
        if (m_state == 0) begin
            if (ev == E_SET && int'(speed) >= MIN_S) begin model_load(int'(speed)); m_state = 1; end
        end else if (m_state == 1) begin
            if (ev == E_BRAKE || ev == E_CANCEL) m_state = 2;
            else if (ev == E_OFF) begin m_state = 0; m_target = 0; m_clr = 1; end
            else if (ev == E_SET && int'(speed) >= MIN_S) model_load(int'(speed));
            else if (ev == E_ACCEL) model_load((m_target + STP > MAX_S) ? MAX_S : m_target + STP);
            else if (ev == E_DECEL) model_load((m_target - STP < MIN_S) ? MIN_S : m_target - STP);
        end else begin
            if (ev == E_RESUME) m_state = 1;
            else if (ev == E_SET && int'(speed) >= MIN_S) begin model_load(int'(speed)); m_state = 1; end
            else if (ev == E_OFF) begin m_state = 0; m_target = 0; m_clr = 1; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        clear = 1; tick(); tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (reg_clear !== 1'b1) begin errors++; $display("FAIL reset_clear got %0b want 1", reg_clear); end
        checks++; if (reg_enable !== 1'b0 || reg_in !== 8'd0 || cruise_active !== 1'b0)
            begin errors++; $display("FAIL reset_outputs en=%0b in=%0d act=%0b want 0/0/0", reg_enable, reg_in, cruise_active); end
        clear = 0; tick();
        checks++; if (reg_clear !== 1'b0 || tb_reg !== 8'd0 || reg_preset !== 1'b0)
            begin errors++; $display("FAIL post_reset clr=%0b reg=%0d pre=%0b want 0/0/0", reg_clear, tb_reg, reg_preset); end
    endtask

    task automatic test_engage();
        speed = 8'd25; set_btn = 1; tick();
        checks++; if (reg_enable !== 1'b0 || state !== 2'b00)
            begin errors++; $display("FAIL engage_low en=%0b st=%0d want 0/0", reg_enable, state); end
        set_btn = 0; tick();
        speed = 8'd60; set_btn = 1; tick();
        checks++; if (reg_enable !== 1'b1 || reg_in !== 8'd60 || state !== 2'b01 || cruise_active !== 1'b1)
            begin errors++; $display("FAIL engage en=%0b in=%0d st=%0d act=%0b want 1/60/1/1", reg_enable, reg_in, state, cruise_active); end
        set_btn = 0; tick();
        checks++; if (reg_enable !== 1'b0 || tb_reg !== 8'd60)
            begin errors++; $display("FAIL engage_reg en=%0b reg=%0d want 0/60", reg_enable, tb_reg); end
    endtask

    task automatic test_accel();
        for (int i = 1; i <= 3; i++) begin
            accel_btn = 1; tick();
            checks++; if (reg_enable !== 1'b1 || reg_in !== 8'(60 + 5 * i))
                begin errors++; $display("FAIL accel_%0d en=%0b in=%0d want 1/%0d", i, reg_enable, reg_in, 60 + 5 * i); end
            accel_btn = 0; tick();
        end
        speed = 8'd198; set_btn = 1; tick(); set_btn = 0; tick();
        for (int i = 0; i < 2; i++) begin
            accel_btn = 1; tick();
            checks++; if (reg_enable !== 1'b1 || reg_in !== 8'd200)
                begin errors++; $display("FAIL accel_sat_%0d en=%0b in=%0d want 1/200", i, reg_enable, reg_in); end
            accel_btn = 0; tick();
        end
        checks++; if (tb_reg !== 8'd200) begin errors++; $display("FAIL accel_reg got %0d want 200", tb_reg); end
    endtask

    task automatic test_decel();
        speed = 8'd32; set_btn = 1; tick(); set_btn = 0; tick();
        for (int i = 0; i < 2; i++) begin
            decel_btn = 1; tick();
            checks++; if (reg_enable !== 1'b1 || reg_in !== 8'd30)
                begin errors++; $display("FAIL decel_sat_%0d en=%0b in=%0d want 1/30", i, reg_enable, reg_in); end
            decel_btn = 0; tick();
        end
        accel_btn = 1; decel_btn = 1; tick();
        checks++; if (reg_enable !== 1'b0 || state !== 2'b01)
            begin errors++; $display("FAIL accel_decel_same en=%0b st=%0d want 0/1", reg_enable, state); end
        accel_btn = 0; decel_btn = 0; tick();
    endtask

    task automatic test_suspend();
        speed = 8'd75; set_btn = 1; tick(); set_btn = 0; tick();
        brake = 1; tick();
        checks++; if (state !== 2'b10 || cruise_active !== 1'b0)
            begin errors++; $display("FAIL brake_suspend st=%0d act=%0b want 2/0", state, cruise_active); end
        resume_btn = 1; tick();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL resume_blocked st=%0d want 2", state); end
        resume_btn = 0; tick(); brake = 0; tick();
        resume_btn = 1; tick();
        checks++; if (state !== 2'b01 || reg_enable !== 1'b0 || cruise_active !== 1'b1)
            begin errors++; $display("FAIL resume st=%0d en=%0b act=%0b want 1/0/1", state, reg_enable, cruise_active); end
        resume_btn = 0; tick();
        checks++; if (tb_reg !== 8'd75) begin errors++; $display("FAIL resume_reg got %0d want 75", tb_reg); end
    endtask

    task automatic test_off();
        off_btn = 1; tick();
        checks++; if (reg_clear !== 1'b1 || state !== 2'b00)
            begin errors++; $display("FAIL off clr=%0b st=%0d want 1/0", reg_clear, state); end
        off_btn = 0; tick();
        checks++; if (reg_clear !== 1'b0 || tb_reg !== 8'd0)
            begin errors++; $display("FAIL off_after clr=%0b reg=%0d want 0/0", reg_clear, tb_reg); end
        speed = 8'd90; set_btn = 1; clear = 1; tick();
        clear = 0; tick(); tick();
        checks++; if (state !== 2'b00 || reg_enable !== 1'b0)
            begin errors++; $display("FAIL set_held_reset st=%0d en=%0b want 0/0", state, reg_enable); end
        set_btn = 0; tick();
    endtask

    task automatic test_reset_vs_set();
        speed = 8'd80; set_btn = 1; clear = 1; tick();
        checks++; if (state !== 2'b00 || reg_enable !== 1'b0 || reg_clear !== 1'b1)
            begin errors++; $display("FAIL reset_vs_set st=%0d en=%0b clr=%0b want 0/0/1", state, reg_enable, reg_clear); end
        clear = 0; set_btn = 0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            clear      = ($urandom_range(0, 99) == 0);
            brake      = ($urandom_range(0, 9) == 0);
            set_btn    = ($urandom_range(0, 3) == 0);
            resume_btn = ($urandom_range(0, 4) == 0);
            cancel_btn = ($urandom_range(0, 9) == 0);
            off_btn    = ($urandom_range(0, 19) == 0);
            accel_btn  = ($urandom_range(0, 2) == 0);
            decel_btn  = ($urandom_range(0, 2) == 0);
            speed      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(25, 35)) : 8'($urandom_range(0, 255));
            tick();
            checks++; if (state !== 2'(m_state) || cruise_active !== (m_state == 1))
                begin errors++; $display("FAIL rand_state c=%0d st=%0d act=%0b want %0d", c, state, cruise_active, m_state); end
            checks++; if (reg_enable !== 1'(m_en) || reg_clear !== 1'(m_clr) || reg_preset !== 1'b0)
                begin errors++; $display("FAIL rand_ctl c=%0d en=%0b clr=%0b want %0d/%0d", c, reg_enable, reg_clear, m_en, m_clr); end
            checks++; if (reg_in !== 8'(m_in) || tb_reg !== 8'(m_reg))
                begin errors++; $display("FAIL rand_data c=%0d in=%0d reg=%0d want %0d/%0d", c, reg_in, tb_reg, m_in, m_reg); end
        end
        clear = 0;
    endtask

    initial begin
        test_reset();
        test_engage();
        test_accel();
        test_decel();
        test_suspend();
        test_off();
        test_reset_vs_set();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
